au_seq: RTL



---
 rtl/au_seq_if.sv | 28 ++
 rtl/au_seq.sv | 92 +++++++++
 2 files changed

// File: rtl/au_seq_if.sv
// au_seq_if: command, response and AU-drive signals of the arithmetic-unit sequencer
interface au_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_chain;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_gf;
  logic       rsp_err;
  logic       au_en;
  logic [3:0] ac;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] t;
  logic       gf;
  modport master (
    output cmd_valid, cmd_op, cmd_chain, cmd_a, cmd_b, rsp_ready, t, gf,
    input  cmd_ready, rsp_valid, rsp_data, rsp_gf, rsp_err, au_en, ac, a, b
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_chain, cmd_a, cmd_b, rsp_ready, t, gf,
    output cmd_ready, rsp_valid, rsp_data, rsp_gf, rsp_err, au_en, ac, a, b
  );
endinterface

// File: rtl/au_seq.sv
// au_seq: sequences requests onto the combinational AU and captures its result
module au_seq #(
  parameter int SETTLE_CYC = 1
) (
  input logic   clk,
  input logic   rst_n,
  au_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam logic [3:0] LAST = 4'(SETTLE_CYC - 1);
  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] acc, acc_n;
  logic       au_en_n;
  logic [3:0] ac_n;
  logic [7:0] a_n, b_n, data_n;
  logic       gf_n, err_n;
  assign bus.cmd_ready = state == IDLE;
  assign bus.rsp_valid = state == RESP;
  // state and every output register, cleared by reset in any state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      acc          <= '0;
      bus.au_en    <= 1'b0;
      bus.ac       <= '0;
      bus.a        <= '0;
      bus.b        <= '0;
      bus.rsp_data <= '0;
      bus.rsp_gf   <= 1'b0;
      bus.rsp_err  <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      acc          <= acc_n;
      bus.au_en    <= au_en_n;
      bus.ac       <= ac_n;
      bus.a        <= a_n;
      bus.b        <= b_n;
      bus.rsp_data <= data_n;
      bus.rsp_gf   <= gf_n;
      bus.rsp_err  <= err_n;
    end
  end
  // next state: AU drive is loaded on accept and dropped on the capture edge
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc_n   = acc;
    au_en_n = bus.au_en;
    ac_n    = bus.ac;
    a_n     = bus.a;
    b_n     = bus.b;
    data_n  = bus.rsp_data;
    gf_n    = bus.rsp_gf;
    err_n   = bus.rsp_err;
    case (state)
      IDLE: if (bus.cmd_valid) begin
        if (bus.cmd_op == 2'b11) begin
          state_n = RESP;
          data_n  = '0;
          gf_n    = 1'b0;
          err_n   = 1'b1;
        end else begin
          state_n = ISSUE;
          cnt_n   = '0;
          au_en_n = 1'b1;
          ac_n    = bus.cmd_op == 2'b00 ? 4'b1000 : bus.cmd_op == 2'b01 ? 4'b1001 : 4'b0100;
          a_n     = bus.cmd_chain ? acc : bus.cmd_a;
          b_n     = bus.cmd_b;
        end
      end
      ISSUE: begin
        cnt_n = cnt + 4'd1;
        if (cnt == LAST) begin
          state_n = RESP;
          data_n  = bus.t;
          gf_n    = bus.gf;
          err_n   = 1'b0;
          acc_n   = bus.t;
          au_en_n = 1'b0;
          ac_n    = '0;
          a_n     = '0;
          b_n     = '0;
        end
      end
      RESP: state_n = bus.rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
endmodule
